fifo_sync_flags: RTL

//  Single-clock synchronous FIFO, successor to the dual-pointer FIFO block.

---
 rtl/fifo_sync_flags.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, optional first-word-fall-through read, and sticky error flags.
module fifo_sync_flags #(
    parameter int N    = 8,
    parameter int DEEP = 8,
    parameter int AW   = $clog2(DEEP),
    parameter int FWFT = 0
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          w_en,
    input  logic [N-1:0]  data_in,
    input  logic          r_en,
    output logic [N-1:0]  data_o,
    output logic          Full,
    output logic          Empty,
    output logic          almost_full,
    output logic          almost_empty,
    input  logic [AW:0]   afull_th,
    input  logic [AW:0]   aempty_th,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    logic [N-1:0] mem [DEEP];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         rd_acc;
    logic         wr_acc;

    assign Empty = (wr_ptr == rd_ptr);
    assign Full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A read out of a full FIFO frees the slot the simultaneous write lands in.
    assign rd_acc = r_en & ~Empty;
    assign wr_acc = w_en & (~Full | rd_acc);

    assign almost_full  = (count >= afull_th);
    assign almost_empty = (count <= aempty_th);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting wins over clearing so an error in the clear cycle is not lost.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en & ~wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en & Empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [N-1:0] data_q;

            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr[AW-1:0]];
                end
            end

            assign data_o = data_q;
        end else begin : g_fwft
            assign data_o = Empty ? '0 : mem[rd_ptr[AW-1:0]];
        end
    endgenerate

endmodule
